// File: rtl/valid_stream_receiver_mem.sv
// Register array for the stream receiver: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owner's occupancy count.
module valid_stream_receiver_mem #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  parameter int unsigned ptr_w = $clog2(depth)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ptr_w-1:0] wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic [ptr_w-1:0] rd_addr,
  output logic [width-1:0] rd_data
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/valid_stream_receiver.sv
// Valid-only upstream to valid/ready downstream adapter: buffers every transfer in a small FIFO
// and raises a sticky overflow flag when a word arrives while the buffer is full and not draining.
module valid_stream_receiver #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4,
  localparam int unsigned cnt_w = $clog2(depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [width-1:0] out_data,
  output logic [cnt_w-1:0] count,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int unsigned ptr_w = cnt_w - 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, push, pop, drop;
  logic [width-1:0] head;

  always_comb begin
    full  = (count_q == full_cnt);
    empty = (count_q == '0);
    pop   = !empty && out_rdy;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    push  = in_vld && (!full || pop);
    drop  = in_vld && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop in the clear cycle is not missed.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  valid_stream_receiver_mem #(
    .width (width),
    .depth (depth),
    .ptr_w (ptr_w)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  // Storage is unreset, so mask the head while empty to keep out_data at zero.
  always_comb begin
    out_vld  = !empty;
    out_data = empty ? '0 : head;
    count    = count_q;
    overflow = overflow_q;
  end

endmodule

// File: tb/tb_valid_stream_receiver.sv
// Bench for valid_stream_receiver: cycle vector table plus hand-written corner sequences,
// with a queue scoreboard that tracks every accepted word, count and the overflow flag.
module tb_valid_stream_receiver;

  localparam int unsigned Width = 8;
  localparam int unsigned Depth = 4;

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [Width-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [Width-1:0] out_data;
  logic [2:0]       count;
  logic             overflow;
  logic             overflow_clr;

  int checks   = 0;
  int failures = 0;

  valid_stream_receiver #(
    .width (Width),
    .depth (Depth)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_data      (in_data),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: model state updated at each negedge for the following rising edge.
  logic [Width-1:0] sb_q[$];
  logic             m_ovf = 1'b0;
  logic             m_pop, m_full;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      m_ovf = 1'b0;
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
    end else begin
      check("sb_count", 32'(count), 32'(sb_q.size()));
      check("sb_out_vld", 32'(out_vld), 32'(sb_q.size() != 0));
      check("sb_overflow", 32'(overflow), 32'(m_ovf));
      if (sb_q.size() != 0) check("sb_out_data", 32'(out_data), 32'(sb_q[0]));
      else check("sb_out_data_idle", 32'(out_data), 32'd0);
      m_full = (sb_q.size() == Depth);
      m_pop  = (sb_q.size() != 0) && out_rdy;
      if (m_pop) void'(sb_q.pop_front());
      if (in_vld && (!m_full || m_pop)) sb_q.push_back(in_data);
      if (in_vld && m_full && !m_pop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       clr;
    logic [2:0] cnt;
    logic       ovld;
    logic [7:0] odata;
    logic       ovf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // inputs applied for one edge; expected outputs observed after that edge
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b0}; // pass-through
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0}; // pop on empty
    vecs[3]  = '{1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 8'h01, 1'b0};
    vecs[4]  = '{1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 1'b1, 8'h01, 1'b0};
    vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 3'd3, 1'b1, 8'h01, 1'b0};
    vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 1'b0};
    vecs[7]  = '{1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 8'h01, 1'b1}; // drop
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 8'h01, 1'b0}; // clear
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h02, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h03, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h04, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 8'h10, 1'b0, 1'b0, 3'd1, 1'b1, 8'h10, 1'b0};
    vecs[14] = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd2, 1'b1, 8'h10, 1'b0};
    vecs[15] = '{1'b1, 8'h12, 1'b0, 1'b0, 3'd3, 1'b1, 8'h10, 1'b0};
    vecs[16] = '{1'b1, 8'h13, 1'b0, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0};
    vecs[17] = '{1'b1, 8'h14, 1'b0, 1'b1, 3'd4, 1'b1, 8'h10, 1'b1}; // drop beats clear
    vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 8'h10, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h10, 1'b0}; // hold under stall

    rst          = 1'b0;
    in_vld       = 1'b0;
    in_data      = '0;
    out_rdy      = 1'b0;
    overflow_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("idle_out_vld", 32'(out_vld), 32'd0);
      check("idle_count", 32'(count), 32'd0);
      check("idle_out_data", 32'(out_data), 32'd0);
      check("idle_overflow", 32'(overflow), 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      in_vld       = vecs[i].vld;
      in_data      = vecs[i].data;
      out_rdy      = vecs[i].rdy;
      overflow_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_out_vld", i), 32'(out_vld), 32'(vecs[i].ovld));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].odata));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    overflow_clr = 1'b0;

    // Full with simultaneous push and pop across several pointer wraps.
    out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_vld  = 1'b1;
      in_data = 8'(8'h20 + i);
      @(posedge clk);
      #1;
      check("stream_count", 32'(count), 32'd4);
      check("stream_overflow", 32'(overflow), 32'd0);
      if (i >= 4) check("stream_out_data", 32'(out_data), 32'(8'h20 + i - 3));
    end
    in_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drain_out_vld", 32'(out_vld), 32'd0);
    check("drain_count", 32'(count), 32'd0);

    // Reset in the middle of a stream.
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_vld  = 1'b1;
      in_data = 8'(8'h40 + i);
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_vld", 32'(out_vld), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    in_vld  = 1'b1;
    in_data = 8'h99;
    @(posedge clk);
    #1;
    check("in_rst_count", 32'(count), 32'd0);
    check("in_rst_overflow", 32'(overflow), 32'd0);
    in_vld = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    in_vld  = 1'b1;
    in_data = 8'h7E;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("post_rst_out_vld", 32'(out_vld), 32'd1);
    check("post_rst_out_data", 32'(out_data), 32'h7E);
    check("post_rst_count", 32'(count), 32'd1);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_drained", 32'(out_vld), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/valid_stream_receiver.md
Name: valid_stream_receiver

Overview:
Receive end of the team's valid-only pipeline interface (in_vld/in_data, no backpressure), such as the output of a valid-tagged shift-register delay line.
Buffers every valid transfer in a small FIFO and re-presents it on a valid/ready interface to a consumer that may stall.
Sits between a fixed-latency arithmetic pipeline and any downstream block with flow control.
Flags a lost transfer when the upstream pushes into a full buffer.

Parameters:
width, 8, data bits per transfer
depth, 4, FIFO entries; power of two, minimum 2
cnt_w, $clog2(depth)+1, derived localparam, width of the occupancy count

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset; 0 resets all state immediately; deassertion is synchronous to clk externally
in_vld  input  1  upstream transfer valid; upstream cannot be stalled
in_data  input  width  upstream data, sampled when in_vld=1
out_vld  output  1  buffer non-empty; out_data holds the oldest entry
out_rdy  input  1  consumer ready; a transfer occurs on a rising edge with out_vld & out_rdy
out_data  output  width  head-of-FIFO data
count  output  cnt_w  entries held, 0..depth
overflow  output  1  sticky: an in_vld transfer was dropped
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, asynchronous): read pointer = write pointer = 0, count=0, out_vld=0, overflow=0, out_data=0. Storage array is not reset.
- Push condition: in_vld & (count<depth | pop), where pop = out_vld & out_rdy.
- Push action: write in_data at wr_ptr; increment wr_ptr modulo depth.
- Pop action: increment rd_ptr modulo depth.
- Pointer wrap: pointers are log2(depth) bits and wrap naturally. Full/empty are taken from count, not from pointer comparison.
- Latency: in_vld at edge N into an empty FIFO gives out_vld=1 and out_data=that word after edge N (one cycle). out_data is read combinationally from mem[rd_ptr]; there is no fall-through bypass of the same cycle.
- Hold rule: while out_vld=1 and out_rdy=0, out_data and out_vld stay stable.
- count: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither. Never exceeds depth and never goes below 0.
- Full with pop: a push and a pop in the same cycle are both accepted and count stays at depth.
- Full without pop: if in_vld=1 and out_rdy=0 with count=depth, the word is dropped, the FIFO is unchanged, and overflow is set at that edge.
- Empty with pop: out_rdy=1 with count=0 has no effect, because pop requires out_vld.
- Empty with push: count goes 0->1 and out_vld rises the next cycle.
- overflow_clr: clears overflow at the edge. If a drop occurs in the same cycle, the set wins and overflow stays 1.
- Mid-operation reset: all contents are discarded immediately and out_vld falls asynchronously. Upstream words arriving during reset are lost and are not counted as overflow.
- No combinational path from in_vld/in_data to any output. out_vld/out_data do not depend on out_rdy in the same cycle.

Decomposition:
- No shared package needed. cnt_w and the pointer width are localparams derived with $clog2(depth).
- One natural sub-module: valid_stream_receiver_mem, a depth x width register array with one synchronous write port and one asynchronous read port.
- Pointer, count and overflow control stay in the top module.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then 1, no in_vld -> out_vld=0, count=0, overflow=0, out_data=0 throughout.
- Single pass-through: out_rdy=1, in_vld pulse with 0xA5 -> out_vld=1 with out_data=0xA5 for exactly one cycle, one edge later; count returns to 0.
- Fill and drain under stall: out_rdy=0, push 0x01,0x02,0x03,0x04 -> count=4, out_data=0x01. Raise out_rdy -> 0x01..0x04 leave in order over 4 cycles, then out_vld=0.
- Overflow and drop: FIFO full with out_rdy=0, push 0x05 -> overflow=1, count=4, 0x05 never appears. Pulse overflow_clr -> overflow=0.
- Full with simultaneous push and pop: FIFO full with out_rdy=1 and continuous in_vld of an incrementing stream for 20 cycles -> count stays 4, no overflow, output sequence is contiguous across several pointer wraps.
- Reset mid-stream: count=3 and rst drops between edges -> out_vld=0 and count=0 immediately. After release, a new push of 0x7E appears as the first output.
